// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the future receiver.
//   - uart_state_e : frame FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   - PAR_EVEN / PAR_ODD : parity-mode constants
//   - calc_parity : parity bit for a payload of up to MAX_DATA_W bits
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Widest payload either side of the link supports.
  localparam int MAX_DATA_W = 9;

  // Even parity is the XOR of the payload; odd parity is its inverse.
  // Callers zero-extend narrower payloads, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                       input logic                  mode);
    return (^data) ^ mode;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time tick generator.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset, clears the counter
//   clr_i  : synchronous clear; holds the counter at zero so the first bit
//            of a frame starts a full bit time after clear drops
//   tick_o : high on the last clk cycle of every CLKS_PER_BIT-cycle bit time
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The counter reloads on every tick, so each bit boundary restarts timing.
  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serial.sv
// UART serial transmitter: start bit, DATA_W payload bits LSB first,
// optional parity bit, STOP_BITS stop bits; each bit lasts CLKS_PER_BIT clks.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset; aborts any frame in flight
//   data_in_uart : payload, captured only on accept
//   load         : request to send data_in_uart
//   ready        : high in IDLE, when a load would be accepted
//   tx           : serial line, idles high
//   busy         : high while a frame is in flight
//   done_out     : one-cycle pulse on the last cycle of the last stop bit
//   dbg_state    : current FSM state, for observation only
//
// Handshake: a transfer happens on a rising clk edge where load and ready are
// both high. load while ready is low is dropped, never queued. Holding load
// high across frames re-accepts on the single IDLE cycle after done_out.
module uart_tx_serial
  import uart_pkg::*;
#(
  parameter int DATA_W       = 7,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in_uart,
  input  logic              load,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done_out,
  output uart_state_e       dbg_state
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic          PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;

  logic              tick;
  logic              baud_clr;

  // Bit timing is held in reset while idle so that the start bit, which
  // begins on the cycle after accept, gets a full bit time.
  assign baud_clr = (state_q == ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (baud_clr),
    .tick_o (tick)
  );

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d    = ST_START;
          shift_d    = data_in_uart;
          // Parity is taken from the payload now, since shifting consumes it.
          parity_d   = calc_parity(MAX_DATA_W'(data_in_uart), PAR_MODE);
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
        end
      end

      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            stop_cnt_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      ST_IDLE:   tx = 1'b1;
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shift_q[0];
      ST_PARITY: tx = parity_q;
      ST_STOP:   tx = 1'b1;
      default:   tx = 1'b1;
    endcase
  end

  assign ready     = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done_out  = (state_q == ST_STOP) && tick && (stop_cnt_q == STOP_LAST);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

endmodule
